// File: rtl/sumador16_seq.sv
// rtl/sumador16_seq.sv - sequences a 4*N_NIB-bit add through the registered 4-bit adder sumador4
// Issues one nibble per cycle, chains RCO back to RCI and assembles SUM/COUT.
module sumador16_seq #(
  parameter int          N_NIB     = 4,
  parameter logic [1:0]  MODO_SUMA = 2'b01
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 START,
  input  logic [4*N_NIB-1:0]   OP_A,
  input  logic [4*N_NIB-1:0]   OP_B,
  input  logic                 CIN,
  output logic                 BUSY,
  output logic                 DONE,
  output logic [4*N_NIB-1:0]   SUM,
  output logic                 COUT,
  output logic                 ADD_ENB,
  output logic [1:0]           ADD_MODO,
  output logic [3:0]           ADD_A,
  output logic [3:0]           ADD_B,
  output logic                 ADD_RCI,
  input  logic [3:0]           ADD_Q,
  input  logic                 ADD_RCO
);

  localparam int              W    = 4 * N_NIB;
  localparam int              CW   = (N_NIB > 1) ? $clog2(N_NIB) : 1;
  localparam logic [CW-1:0]   LAST = CW'(N_NIB - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic            cin_q, cin_d;
  logic [W-1:0]    sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            add_enb_q, add_enb_d;
  logic [3:0]      add_a_q, add_a_d;
  logic [3:0]      add_b_q, add_b_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    a_d       = a_q;
    b_d       = b_q;
    cin_d     = cin_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    add_enb_d = 1'b0;
    add_a_d   = 4'h0;
    add_b_d   = 4'h0;

    case (state_q)
      IDLE: begin
        if (START) begin
          a_d     = OP_A;
          b_d     = OP_B;
          cin_d   = CIN;
          cnt_d   = '0;
          sum_d   = '0;
          cout_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        // Q from the previous issue is valid now; store it under the previous nibble.
        if (cnt_q != '0) begin
          sum_d[4*(int'(cnt_q) - 1) +: 4] = ADD_Q;
        end
        if (cnt_q == LAST) begin
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRAIN: begin
        sum_d[W-4 +: 4] = ADD_Q;
        cout_d          = ADD_RCO;
        busy_d          = 1'b0;
        done_d          = 1'b1;
        cnt_d           = '0;
        state_d         = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Adder drive is registered, so it is computed from the state being entered.
    if (state_d == ISSUE) begin
      add_enb_d = 1'b1;
      add_a_d   = a_d[4*int'(cnt_d) +: 4];
      add_b_d   = b_d[4*int'(cnt_d) +: 4];
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      cin_q     <= 1'b0;
      sum_q     <= '0;
      cout_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      add_enb_q <= 1'b0;
      add_a_q   <= 4'h0;
      add_b_q   <= 4'h0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      a_q       <= a_d;
      b_q       <= b_d;
      cin_q     <= cin_d;
      sum_q     <= sum_d;
      cout_q    <= cout_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      add_enb_q <= add_enb_d;
      add_a_q   <= add_a_d;
      add_b_q   <= add_b_d;
    end
  end

  // Carry chain: nibble 0 takes the latched CIN, later nibbles take the adder's live RCO.
  always_comb begin
    ADD_RCI = 1'b0;
    if (state_q == ISSUE) begin
      ADD_RCI = (cnt_q == '0) ? cin_q : ADD_RCO;
    end
  end

  assign BUSY     = busy_q;
  assign DONE     = done_q;
  assign SUM      = sum_q;
  assign COUT     = cout_q;
  assign ADD_ENB  = add_enb_q;
  assign ADD_A    = add_a_q;
  assign ADD_B    = add_b_q;
  assign ADD_MODO = MODO_SUMA;

endmodule
